// File: rtl/servo_pulse_decoder.sv
// Hobby-servo PWM receiver: measures each high pulse on srv_i and returns an
// N-bit position, flags short/overrange pulses and tracks frame-stream lock.
module servo_pulse_decoder #(
    parameter int unsigned CLK_PER_NS       = 40,
    parameter int unsigned N                = 8,
    parameter int unsigned STEP_NS          = 3920,
    parameter int unsigned FRAME_TIMEOUT_MS = 25
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         srv_i,
    output logic [N-1:0] position_o,
    output logic         valid_o,
    output logic         err_o,
    output logic         locked_o
);

    localparam int unsigned MS_CYC    = 1000000 / CLK_PER_NS;
    localparam int unsigned STEP_DIV  = STEP_NS / CLK_PER_NS;
    localparam int unsigned STEP_CYC  = (STEP_DIV == 0) ? 1 : STEP_DIV;
    localparam int unsigned MS_W      = $clog2(MS_CYC + 1);
    localparam int unsigned PSC_W     = $clog2(STEP_CYC + 1);
    localparam int unsigned TMO_W     = $clog2(FRAME_TIMEOUT_MS + 1);
    // The last base cycle already counts as the first step cycle.
    localparam int unsigned PSC_INIT  = (STEP_CYC == 1) ? 0 : 1;
    localparam int unsigned STEP_INIT = (STEP_CYC == 1) ? 1 : 0;

    typedef enum logic [2:0] {S_ARM, S_LOW, S_BASE, S_STEP, S_HIGH} state_t;

    state_t             state, state_d;
    logic               s1, s2, s3;
    logic               rise, fall;
    logic [MS_W-1:0]    cyc_cnt, cyc_d;
    logic [PSC_W-1:0]   psc, psc_d;
    logic [N-1:0]       step_cnt, step_d;
    logic [MS_W-1:0]    ms_psc, ms_psc_d;
    logic [TMO_W-1:0]   ms_cnt, ms_cnt_d;
    logic [N-1:0]       pos_d;
    logic               valid_d, err_d, locked_d;
    logic               step_wrap;

    assign rise      = s2 & ~s3;
    assign fall      = ~s2 & s3;
    assign step_wrap = (psc == PSC_W'(STEP_CYC - 1));

    // Synchroniser resets high so a pulse in progress at release is never seen as a rise.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1         <= 1'b1;
            s2         <= 1'b1;
            s3         <= 1'b1;
            state      <= S_ARM;
            cyc_cnt    <= '0;
            psc        <= '0;
            step_cnt   <= '0;
            ms_psc     <= '0;
            ms_cnt     <= '0;
            position_o <= '0;
            valid_o    <= 1'b0;
            err_o      <= 1'b0;
            locked_o   <= 1'b0;
        end else begin
            s1         <= srv_i;
            s2         <= s1;
            s3         <= s2;
            state      <= state_d;
            cyc_cnt    <= cyc_d;
            psc        <= psc_d;
            step_cnt   <= step_d;
            ms_psc     <= ms_psc_d;
            ms_cnt     <= ms_cnt_d;
            position_o <= pos_d;
            valid_o    <= valid_d;
            err_o      <= err_d;
            locked_o   <= locked_d;
        end
    end

    always_comb begin
        state_d  = state;
        cyc_d    = cyc_cnt;
        psc_d    = psc;
        step_d   = step_cnt;
        ms_psc_d = ms_psc;
        ms_cnt_d = ms_cnt;
        pos_d    = position_o;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        locked_d = locked_o;

        // Frame timeout: ms prescaler plus saturating ms counter, restarted by every rise.
        if (state == S_ARM || rise) begin
            ms_psc_d = '0;
            ms_cnt_d = '0;
        end else if (ms_psc == MS_W'(MS_CYC - 1)) begin
            ms_psc_d = '0;
            if (ms_cnt != TMO_W'(FRAME_TIMEOUT_MS)) ms_cnt_d = ms_cnt + 1'b1;
            if (ms_cnt == TMO_W'(FRAME_TIMEOUT_MS - 1)) locked_d = 1'b0;
        end else begin
            ms_psc_d = ms_psc + 1'b1;
        end

        case (state)
            S_ARM: if (!s2) state_d = S_LOW;
            S_LOW: begin
                if (rise) begin
                    cyc_d   = '0;
                    state_d = S_BASE;
                end
            end
            S_BASE: begin
                cyc_d = cyc_cnt + 1'b1;
                if (fall) begin
                    // A fall on the final base cycle is exactly 1 ms: position 0.
                    if (cyc_cnt == MS_W'(MS_CYC - 1)) begin
                        pos_d    = '0;
                        valid_d  = 1'b1;
                        locked_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = S_LOW;
                end else if (cyc_cnt == MS_W'(MS_CYC - 1)) begin
                    psc_d   = PSC_W'(PSC_INIT);
                    step_d  = N'(STEP_INIT);
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                if (step_wrap) begin
                    psc_d = '0;
                    if (step_cnt != '1) step_d = step_cnt + 1'b1;
                end else begin
                    psc_d = psc + 1'b1;
                end
                if (fall) begin
                    pos_d    = step_cnt;
                    valid_d  = 1'b1;
                    locked_d = 1'b1;
                    state_d  = S_LOW;
                end else if (step_cnt == '1 && step_wrap) begin
                    err_d   = 1'b1;
                    state_d = S_HIGH;
                end
            end
            S_HIGH: if (fall) state_d = S_LOW;
            default: state_d = S_ARM;
        endcase

        if (!en_i) begin
            state_d  = S_ARM;
            valid_d  = 1'b0;
            err_d    = 1'b0;
            locked_d = 1'b0;
            ms_psc_d = '0;
            ms_cnt_d = '0;
        end
    end

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Scoreboard bench for servo_pulse_decoder, scaled to 1 us clock so the
// whole run stays short: MS_CYC=1000, STEP_CYC=4, timeout 5 ms.
module tb_servo_pulse_decoder;

    localparam int unsigned MS_CYC   = 1000;
    localparam int unsigned STEP_CYC = 4;
    localparam int unsigned TMO_MS   = 5;

    localparam int K_VALID = 0;
    localparam int K_SHORT = 1;
    localparam int K_OVR   = 2;

    typedef struct {
        bit          is_err;
        logic [7:0]  pos;
        int unsigned at;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, en, srv;
    logic [7:0] position;
    logic       valid, err, locked;

    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic [7:0]  exp_pos = '0;
    exp_t        sb[$];

    servo_pulse_decoder #(
        .CLK_PER_NS(1000),
        .N(8),
        .STEP_NS(4000),
        .FRAME_TIMEOUT_MS(TMO_MS)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .en_i(en),
        .srv_i(srv),
        .position_o(position),
        .valid_o(valid),
        .err_o(err),
        .locked_o(locked)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input bit is_err, input logic [7:0] pos, input int unsigned at);
        exp_t e;
        e.is_err = is_err;
        e.pos    = pos;
        e.at     = at;
        sb.push_back(e);
    endtask

    // Pulse of hi cycles; a strobe is expected 3 edges after the fall is driven.
    task automatic pulse(input int hi, input int lo, input int kind, input logic [7:0] pos);
        int unsigned r;
        int unsigned f;
        r   = cyc;
        srv = 1'b1;
        // Overrange is reached once the high time hits MS + 256 steps.
        if (kind == K_OVR) push(1'b1, exp_pos, r + 2 + MS_CYC + 256 * STEP_CYC);
        hold(hi);
        srv = 1'b0;
        f   = cyc;
        if (kind == K_VALID) begin
            exp_pos = pos;
            push(1'b0, pos, f + 3);
        end else if (kind == K_SHORT) begin
            push(1'b1, exp_pos, f + 3);
        end
        hold(lo);
    endtask

    // Monitor: every strobe must match the head of the scoreboard, on time.
    always @(negedge clk) begin
        exp_t e;
        if (valid && err) check("strobe_overlap", 1, 0);
        if (valid || err) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe valid=%0d err=%0d cycle=%0d", valid, err, cyc);
            end else begin
                e = sb.pop_front();
                check("strobe_kind_err", longint'(err), longint'(e.is_err));
                check("strobe_position", longint'(position), longint'(e.pos));
                check("strobe_cycle", longint'(cyc), longint'(e.at));
            end
        end else if (sb.size() > 0 && cyc > sb[0].at) begin
            e = sb.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_strobe actual=none required=%s at cycle %0d",
                     e.is_err ? "err" : "valid", e.at);
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int unsigned r;
        rst = 1'b1;
        en  = 1'b1;
        srv = 1'b0;
        hold(5);
        check("reset_position", longint'(position), 0);
        check("reset_valid", longint'(valid), 0);
        check("reset_err", longint'(err), 0);
        check("reset_locked", longint'(locked), 0);
        rst = 1'b0;
        hold(10);

        // Nominal decodes and step boundaries
        pulse(1500, 300, K_VALID, 8'd125);
        check("locked_after_first", longint'(locked), 1);
        pulse(2000, 300, K_VALID, 8'd250);
        pulse(1000, 300, K_VALID, 8'd0);
        pulse(1003, 300, K_VALID, 8'd0);
        pulse(1004, 300, K_VALID, 8'd1);
        pulse(2023, 300, K_VALID, 8'd255);

        // Malformed pulses leave position untouched
        pulse(900, 300, K_SHORT, 8'd0);
        pulse(999, 300, K_SHORT, 8'd0);
        pulse(2100, 300, K_OVR, 8'd0);
        pulse(2024, 300, K_OVR, 8'd0);
        check("position_held_after_err", longint'(position), 255);

        // Frame timeout: locked drops exactly TMO_MS after the last rise
        pulse(1500, 500, K_VALID, 8'd125);
        pulse(1500, 500, K_VALID, 8'd125);
        r   = cyc;
        srv = 1'b1;
        hold(1500);
        srv = 1'b0;
        push(1'b0, 8'd125, cyc + 3);
        hold(3 + TMO_MS * MS_CYC - 1 - 1500);
        check("locked_before_timeout", longint'(locked), 1);
        check("timeout_offset", longint'(cyc - r), 3 + TMO_MS * MS_CYC - 1);
        hold(1);
        check("locked_at_timeout", longint'(locked), 0);
        hold(1000);
        check("locked_stays_low", longint'(locked), 0);
        pulse(1500, 300, K_VALID, 8'd125);
        check("locked_relock", longint'(locked), 1);

        // Enable dropped mid-pulse: abort, re-arm on low
        pulse(1200, 300, K_VALID, 8'd50);
        srv = 1'b1;
        hold(1300);
        en = 1'b0;
        hold(2);
        check("locked_en_low", longint'(locked), 0);
        check("position_en_low", longint'(position), 50);
        en = 1'b1;
        hold(200);
        srv = 1'b0;
        hold(300);
        pulse(1500, 300, K_VALID, 8'd125);

        // Reset mid-pulse
        srv = 1'b1;
        hold(1300);
        rst = 1'b1;
        hold(3);
        exp_pos = '0;
        check("locked_rst_mid", longint'(locked), 0);
        check("position_rst_mid", longint'(position), 0);
        rst = 1'b0;
        hold(200);
        srv = 1'b0;
        hold(300);
        pulse(1200, 300, K_VALID, 8'd50);

        // srv high across reset release; first partial pulse ignored
        rst = 1'b1;
        srv = 1'b1;
        hold(5);
        exp_pos = '0;
        rst = 1'b0;
        hold(500);
        srv = 1'b0;
        hold(300);
        pulse(1200, 300, K_VALID, 8'd50);
        check("locked_after_rearm", longint'(locked), 1);

        hold(50);
        check("scoreboard_drained", longint'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
